// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the M-stage load/store port.
// Serves byte-strobed writes and word reads after WAIT wait states, stalling the pipeline meanwhile.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int WAIT       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  inr_q;
    logic [3:0]            wen_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  rvld_q;
    logic                  aerr_q;
    logic [31:0]           mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  req_inr;
    logic                  unused_addr_bits;

    logic                  acc_go;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  acc_inr;
    logic [3:0]            acc_wen;
    logic [31:0]           acc_wdata;

    assign req_idx          = addr[ADDR_WIDTH+1:2];
    assign req_inr          = (addr[31:ADDR_WIDTH+2] == '0);
    assign unused_addr_bits = ^addr[1:0];

    // The access is taken either straight from the pipeline (WAIT == 0) or from the latched request.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        acc_go    = 1'b0;
        acc_idx   = idx_q;
        acc_inr   = inr_q;
        acc_wen   = wen_q;
        acc_wdata = wdata_q;
        case (state_q)
            IDLE: begin
                stall = en;
                if (en) begin
                    if (WAIT == 0) begin
                        acc_go    = 1'b1;
                        acc_idx   = req_idx;
                        acc_inr   = req_inr;
                        acc_wen   = wen;
                        acc_wdata = wdata;
                        state_d   = DONE;
                    end else begin
                        cnt_d   = WAIT_CNT;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    acc_go  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Reset must also block an access that would otherwise commit on this edge.
        if (rst) begin
            stall  = 1'b0;
            acc_go = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            rvld_q  <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rvld_q  <= acc_go && (acc_wen == 4'b0000);
            aerr_q  <= acc_go && !acc_inr;
            if (acc_go && (acc_wen == 4'b0000)) begin
                rdata_q <= acc_inr ? mem_q[acc_idx] : 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && en) begin
            idx_q   <= req_idx;
            inr_q   <= req_inr;
            wen_q   <= wen;
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_go && acc_inr) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wen[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rvld_q;
    assign addr_err    = aerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT=2 instance (a_*) and a WAIT=0 instance (b_*).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, b_en;
    logic [3:0]  a_wen, b_wen;
    logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_rv, b_rv, a_ae, b_ae, a_stall, b_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT(2)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .wen(a_wen), .addr(a_addr), .wdata(a_wdata),
        .rdata(a_rdata), .rdata_valid(a_rv), .addr_err(a_ae), .stall(a_stall)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT(0)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .wen(b_wen), .addr(b_addr), .wdata(b_wdata),
        .rdata(b_rdata), .rdata_valid(b_rv), .addr_err(b_ae), .stall(b_stall)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds a request on dut_a until stall drops; returns the stall trace and DONE-cycle outputs.
    task automatic issue_a(input logic [31:0] ad, input logic [3:0] w, input logic [31:0] d,
                           output logic [7:0] st, output int n, output logic [31:0] rd,
                           output logic rv, output logic ae);
        st = '0; n = 99; rd = '0; rv = 1'b0; ae = 1'b0;
        a_en = 1'b1; a_addr = ad; a_wen = w; a_wdata = d;
        for (int i = 0; i < 8; i++) begin
            #1;
            st[i] = a_stall;
            if (a_stall == 1'b0) begin
                n = i; rd = a_rdata; rv = a_rv; ae = a_ae;
                step();
                break;
            end
            step();
        end
        a_en = 1'b0; a_wen = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_en = 1'b1; a_wen = 4'b0000; a_addr = 32'h0; a_wdata = 32'h0;
        b_en = 1'b1; b_wen = 4'b0000; b_addr = 32'h0; b_wdata = 32'h0;
        step(); step();
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", a_stall); end
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", a_rdata); end
        checks++; if (a_rv !== 1'b0 || a_ae !== 1'b0) begin errors++; $display("FAIL reset_flags: got rv=%b ae=%b expected 0,0", a_rv, a_ae); end
        checks++; if (b_stall !== 1'b0 || b_rdata !== 32'h0) begin errors++; $display("FAIL reset_b: got stall=%b rdata=%h expected 0,0", b_stall, b_rdata); end
        step();
        rst = 1'b0; a_en = 1'b0; b_en = 1'b0;
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b expected 0", a_stall); end
        step();
    endtask

    task automatic test_write_read();
        logic [7:0] st; int n; logic [31:0] rd; logic rv, ae;
        issue_a(32'h10, 4'b1111, 32'hDEADBEEF, st, n, rd, rv, ae);
        checks++; if (st !== 8'h07 || n != 3) begin errors++; $display("FAIL write_stall: got %b n=%0d expected 00000111 n=3", st, n); end
        checks++; if (rv !== 1'b0 || ae !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL write_done: got rv=%b ae=%b rd=%h expected 0,0,0", rv, ae, rd); end
        issue_a(32'h10, 4'b0000, 32'h0, st, n, rd, rv, ae);
        checks++; if (st !== 8'h07 || n != 3) begin errors++; $display("FAIL read_stall: got %b n=%0d expected 00000111 n=3", st, n); end
        checks++; if (rd !== 32'hDEADBEEF || rv !== 1'b1 || ae !== 1'b0) begin errors++; $display("FAIL read_data: got %h rv=%b ae=%b expected deadbeef,1,0", rd, rv, ae); end
        #1;
        checks++; if (a_rv !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_after: got rv=%b rdata=%h expected 0,deadbeef", a_rv, a_rdata); end
        step();
    endtask

    task automatic test_byte_write();
        logic [7:0] st; int n; logic [31:0] rd; logic rv, ae;
        issue_a(32'h10, 4'b0100, 32'h00AA0000, st, n, rd, rv, ae);
        checks++; if (rd !== 32'hDEADBEEF || rv !== 1'b0) begin errors++; $display("FAIL byte_write_done: got rd=%h rv=%b expected deadbeef,0", rd, rv); end
        issue_a(32'h10, 4'b0000, 32'h0, st, n, rd, rv, ae);
        checks++; if (rd !== 32'hDEAABEEF || rv !== 1'b1) begin errors++; $display("FAIL byte_read: got %h rv=%b expected deaabeef,1", rd, rv); end
    endtask

    task automatic test_out_of_range();
        logic [7:0] st; int n; logic [31:0] rd; logic rv, ae;
        issue_a(32'h0, 4'b1111, 32'hCAFEF00D, st, n, rd, rv, ae);
        checks++; if (ae !== 1'b0) begin errors++; $display("FAIL inrange_write_err: got %b expected 0", ae); end
        issue_a(32'h1000, 4'b1111, 32'h12345678, st, n, rd, rv, ae);
        checks++; if (ae !== 1'b1 || rv !== 1'b0) begin errors++; $display("FAIL oor_write: got ae=%b rv=%b expected 1,0", ae, rv); end
        #1;
        checks++; if (a_ae !== 1'b0) begin errors++; $display("FAIL oor_err_clear: got %b expected 0", a_ae); end
        step();
        issue_a(32'h1000, 4'b0000, 32'h0, st, n, rd, rv, ae);
        checks++; if (rd !== 32'h0 || ae !== 1'b1 || rv !== 1'b1) begin errors++; $display("FAIL oor_read: got rd=%h ae=%b rv=%b expected 0,1,1", rd, ae, rv); end
        issue_a(32'h0, 4'b0000, 32'h0, st, n, rd, rv, ae);
        checks++; if (rd !== 32'hCAFEF00D || ae !== 1'b0) begin errors++; $display("FAIL read_word0: got rd=%h ae=%b expected cafef00d,0", rd, ae); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] st; int n; logic [31:0] rd; logic rv, ae;
        issue_a(32'h20, 4'b1111, 32'h22222222, st, n, rd, rv, ae);
        a_en = 1'b1; a_addr = 32'h20; a_wen = 4'b1111; a_wdata = 32'h11111111;
        #1;
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL mid_idle_stall: got %b expected 1", a_stall); end
        step();
        rst = 1'b1;
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall: got %b expected 0", a_stall); end
        step();
        rst = 1'b0; a_en = 1'b0; a_wen = 4'b0000;
        #1;
        checks++; if (a_stall !== 1'b0 || a_rdata !== 32'h0) begin errors++; $display("FAIL mid_after_rst: got stall=%b rdata=%h expected 0,0", a_stall, a_rdata); end
        checks++; if (a_rv !== 1'b0 || a_ae !== 1'b0) begin errors++; $display("FAIL mid_flags: got rv=%b ae=%b expected 0,0", a_rv, a_ae); end
        step();
        issue_a(32'h20, 4'b0000, 32'h0, st, n, rd, rv, ae);
        checks++; if (rd !== 32'h22222222) begin errors++; $display("FAIL mid_preserved: got %h expected 22222222", rd); end
    endtask

    task automatic test_busy_ignore();
        logic [3:0] s; logic [31:0] rd; logic rv;
        logic [7:0] st; int n; logic [31:0] rd2; logic rv2, ae2;
        a_en = 1'b1; a_addr = 32'h10; a_wen = 4'b0000; a_wdata = 32'h0;
        #1; s[0] = a_stall;
        step();
        a_addr = 32'h20; a_wen = 4'b1111; a_wdata = 32'h55555555;
        #1; s[1] = a_stall;
        step();
        #1; s[2] = a_stall;
        step();
        #1; s[3] = a_stall; rd = a_rdata; rv = a_rv;
        step();
        a_en = 1'b0; a_wen = 4'b0000;
        checks++; if (s !== 4'b0111) begin errors++; $display("FAIL busy_stall: got %b expected 0111", s); end
        checks++; if (rd !== 32'hDEAABEEF || rv !== 1'b1) begin errors++; $display("FAIL busy_read: got %h rv=%b expected deaabeef,1", rd, rv); end
        issue_a(32'h20, 4'b0000, 32'h0, st, n, rd2, rv2, ae2);
        checks++; if (rd2 !== 32'h22222222) begin errors++; $display("FAIL busy_no_write: got %h expected 22222222", rd2); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4] = '{32'hA0A00001, 32'hB1B10002, 32'hC2C20003, 32'hD3D30004};
        logic [7:0] st;
        st = '0;
        b_en = 1'b1; b_wen = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            b_addr = 32'(4 * i); b_wdata = vals[i];
            step(); step();
        end
        b_wen = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            b_addr = 32'(4 * i);
            #1; st[2*i] = b_stall;
            step();
            #1; st[2*i+1] = b_stall;
            checks++; if (b_rdata !== vals[i] || b_rv !== 1'b1) begin errors++; $display("FAIL b2b_read%0d: got %h rv=%b expected %h,1", i, b_rdata, b_rv, vals[i]); end
            step();
        end
        b_en = 1'b0;
        checks++; if (st !== 8'h55) begin errors++; $display("FAIL b2b_stall: got %b expected 01010101", st); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_out_of_range();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the datapath's M-stage load/store port: accepts the address, byte-write strobes and lane-aligned write data the pipeline drives, performs the access against an internal word-organised RAM after a configurable number of wait states, and returns read data. It drives a stall line so the pipeline holds the M-stage instruction until the access completes. It replaces the zero-latency data RAM and gives the hazard unit a real multi-cycle memory to stall on.

## Interface
- ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words; valid byte range 0 .. 2^(ADDR_WIDTH+2)-1
- WAIT, 2, wait-state cycles per access, 0..15
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  access request from M stage (load or store)
- wen  in  4  byte write strobes, bit i writes byte lane i; 4'b0000 = read
- addr  in  32  byte address (ALU result in M); addr[1:0] ignored
- wdata  in  32  store data, already lane-aligned
- rdata  out  32  read data, registered
- rdata_valid  out  1  read result present this cycle
- addr_err  out  1  completed access was out of range
- stall  out  1  hold pipeline; combinational from state and en

## Operation
- Word index = addr[ADDR_WIDTH+1:2]; in range iff addr[31:ADDR_WIDTH+2] == 0.
- RAM contents are not reset; only control state and outputs are.
- States: IDLE, BUSY, DONE. Counter cnt, 4 bits.
- IDLE: stall = en. On edge with en=1: latch addr, wen, wdata. If WAIT==0, perform access and go DONE; else cnt <= WAIT, go BUSY. en=0: stay, no access regardless of wen.
- BUSY: stall = 1. Each edge cnt <= cnt-1; on edge where cnt==1, perform access with latched request, go DONE. en/addr/wen/wdata changes during BUSY ignored.
- DONE: stall = 0 (pipeline advances at this edge). Next edge -> IDLE unconditionally.
- Access: write (latched wen != 0): each set strobe byte i of RAM word <= wdata[8i+7:8i]; unset bytes unchanged. Read (wen == 0): rdata <= full RAM word.
- Out of range: write suppressed, read loads rdata <= 0; addr_err = 1 for the DONE cycle.
- rdata holds its value until the next read completes; writes never change rdata.
- rdata_valid = 1 only in DONE for a read; addr_err = 1 only in DONE.

## Timing
- Reset values: state IDLE, cnt 0, rdata 0, rdata_valid 0, addr_err 0; stall forced 0 while rst=1.
- Request cycle counts: stall high for 1+WAIT cycles (IDLE cycle + WAIT BUSY cycles), then one DONE cycle with stall low. Access committed at the edge entering DONE.
- Minimum spacing: WAIT+2 cycles per access; next request is seen in IDLE the cycle after DONE.
- Read data visible in DONE, i.e. 1+WAIT cycles after the request cycle; W stage captures it at the DONE edge.
- Reset mid-operation (BUSY or DONE): next cycle IDLE, all outputs at reset values; an uncommitted write is discarded; a write committed before reset remains in RAM.
- en=1 in DONE is treated as the old request still held and is not re-issued.

## Test plan
- WAIT=2, ADDR_WIDTH=10: after reset, write addr 0x0000_0010, wen 4'b1111, wdata 0xDEADBEEF -> stall 1,1,1,0; then read 0x10 -> stall 1,1,1,0, rdata 0xDEADBEEF with rdata_valid=1 in DONE.
- Byte write wen 4'b0100, wdata 0x00AA_0000 to 0x10, then read 0x10 -> rdata 0xDEAABEEF; rdata unchanged (0xDEADBEEF) during the write's DONE cycle.
- Write 0x1234_5678 to 0x0000_1000 (out of range) -> addr_err=1 in DONE; read 0x1000 -> rdata 0, addr_err=1; read 0x0000_0000 after writing 0xCAFEF00D there -> 0xCAFEF00D, addr_err=0.
- Preload 0x20 with 0x2222_2222; issue write 0x1111_1111 to 0x20, assert rst in first BUSY cycle -> next cycle IDLE, stall 0, rdata 0; later read 0x20 -> 0x2222_2222.
- During BUSY of a read to 0x10, change addr to 0x20 and wen to 4'b1111 -> RAM 0x20 unchanged, rdata = word at 0x10.
- WAIT=0 instance: four back-to-back reads held until stall drops -> stall pattern 1,0,1,0,1,0,1,0, each DONE returns correct word.
